// File: rtl/lif_sequencer.sv
// rtl/lif_sequencer.sv - time-multiplexed leaky integrate-and-fire neuron sweep with AER spike output
// One neuron is updated per cycle; each spike pauses the sweep until its event is accepted.
module lif_sequencer #(
   parameter int         N_NEURONS = 8,
   parameter logic [7:0] GAIN      = 8'd64,
   localparam int        AW        = $clog2(N_NEURONS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 clear,
   input  logic [N_NEURONS-1:0] current,
   input  logic [7:0]           beta,
   input  logic [7:0]           threshold,
   input  logic                 aer_ready,
   output logic                 aer_valid,
   output logic [AW-1:0]        aer_addr,
   output logic                 busy,
   output logic                 done,
   output logic [N_NEURONS-1:0] spike_vec,
   output logic [AW:0]          spike_count,
   input  logic [AW-1:0]        mem_sel,
   output logic [7:0]           state_out
);

   typedef enum logic [1:0] {IDLE, UPDATE, EMIT, DONE} state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);

   state_t               state;
   logic [AW-1:0]        idx;
   logic [7:0]           mem [N_NEURONS];
   logic [N_NEURONS-1:0] cur_q;
   logic [N_NEURONS-1:0] acc;
   logic [7:0]           beta_q;
   logic [7:0]           thr_q;

   logic [15:0]          prod;
   logic [7:0]           decayed;
   logic [8:0]           sum;
   logic [7:0]           next_mem;
   logic                 fire;
   logic                 last;
   logic [AW:0]          acc_count;

   // Decay keeps the upper byte of the 8x8 product; the gain add saturates at 255.
   always_comb begin
      prod     = {8'd0, mem[idx]} * {8'd0, beta_q};
      decayed  = 8'(prod >> 8);
      sum      = {1'b0, decayed} + (cur_q[idx] ? {1'b0, GAIN} : 9'd0);
      next_mem = sum[8] ? 8'hFF : sum[7:0];
      fire     = (next_mem >= thr_q);
      last     = (idx == LAST_IDX);
   end

   always_comb begin
      acc_count = '0;
      for (int i = 0; i < N_NEURONS; i++) begin
         acc_count = acc_count + (AW+1)'(acc[i]);
      end
   end

   assign state_out = mem[mem_sel];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         cur_q       <= '0;
         beta_q      <= '0;
         thr_q       <= '0;
         acc         <= '0;
         spike_vec   <= '0;
         spike_count <= '0;
         aer_valid   <= 1'b0;
         aer_addr    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         for (int i = 0; i < N_NEURONS; i++) begin
            mem[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (clear) begin
                  for (int i = 0; i < N_NEURONS; i++) begin
                     mem[i] <= '0;
                  end
               end else if (start) begin
                  cur_q  <= current;
                  beta_q <= beta;
                  thr_q  <= threshold;
                  acc    <= '0;
                  idx    <= '0;
                  busy   <= 1'b1;
                  state  <= UPDATE;
               end
            end
            UPDATE: begin
               if (fire) begin
                  mem[idx]  <= '0;
                  acc[idx]  <= 1'b1;
                  aer_valid <= 1'b1;
                  aer_addr  <= idx;
                  state     <= EMIT;
               end else begin
                  mem[idx] <= next_mem;
                  if (last) begin
                     spike_vec   <= acc;
                     spike_count <= acc_count;
                     done        <= 1'b1;
                     state       <= DONE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            EMIT: begin
               // acc already holds this neuron's bit, so it can be published directly.
               if (aer_ready) begin
                  aer_valid <= 1'b0;
                  if (last) begin
                     spike_vec   <= acc;
                     spike_count <= acc_count;
                     done        <= 1'b1;
                     state       <= DONE;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= UPDATE;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy      <= 1'b0;
               aer_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lif_sequencer.sv
// tb/tb_lif_sequencer.sv - self-checking bench for lif_sequencer
// Table rows, hand-written corner sequences and randomized sweeps against a behavioural model.
module tb_lif_sequencer;

   localparam int N  = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          clear;
   logic [N-1:0]  current;
   logic [7:0]    beta;
   logic [7:0]    threshold;
   logic          aer_ready;
   logic [AW-1:0] mem_sel;

   logic          aer_valid, s_aer_valid;
   logic [AW-1:0] aer_addr, s_aer_addr;
   logic          busy, s_busy;
   logic          done, s_done;
   logic [N-1:0]  spike_vec, s_spike_vec;
   logic [AW:0]   spike_count, s_spike_count;
   logic [7:0]    state_out, s_state_out;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            exp_mem [N];
   int            model_mem [N];
   logic [N-1:0]  exp_vec;

   typedef struct {
      logic         clr;
      logic [N-1:0] cur;
      logic [7:0]   beta;
      logic [7:0]   thr;
      logic [N-1:0] vec;
      int           on_v;
      int           off_v;
   } row_t;

   row_t tbl [11];

   lif_sequencer #(.N_NEURONS(N), .GAIN(8'd64)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .current(current),
      .beta(beta), .threshold(threshold), .aer_ready(aer_ready),
      .aer_valid(aer_valid), .aer_addr(aer_addr), .busy(busy), .done(done),
      .spike_vec(spike_vec), .spike_count(spike_count),
      .mem_sel(mem_sel), .state_out(state_out)
   );

   lif_sequencer #(.N_NEURONS(N), .GAIN(8'd200)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .current(current),
      .beta(beta), .threshold(threshold), .aer_ready(aer_ready),
      .aer_valid(s_aer_valid), .aer_addr(s_aer_addr), .busy(s_busy), .done(s_done),
      .spike_vec(s_spike_vec), .spike_count(s_spike_count),
      .mem_sel(mem_sel), .state_out(s_state_out)
   );

   always #10 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_mems(input string tag);
      for (int i = 0; i < N; i++) begin
         mem_sel = AW'(i);
         #1;
         check($sformatf("%s mem%0d", tag, i), 32'(state_out), exp_mem[i]);
      end
   endtask

   task automatic set_exp(input logic [N-1:0] cur, input logic [N-1:0] vec, input int on_v, input int off_v);
      exp_vec = vec;
      for (int i = 0; i < N; i++) exp_mem[i] = cur[i] ? on_v : off_v;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   // Reference: apply the neuron rules one by one with plain integer arithmetic.
   task automatic model_sweep(input logic [N-1:0] c, input int b, input int t, input int gain,
                              output logic [N-1:0] vec);
      int nx;
      vec = '0;
      for (int i = 0; i < N; i++) begin
         nx = (model_mem[i] * b) / 256 + (c[i] ? gain : 0);
         if (nx > 255) nx = 255;
         if (nx >= t) begin
            vec[i] = 1'b1;
            model_mem[i] = 0;
         end else begin
            model_mem[i] = nx;
         end
      end
   endtask

   task automatic run_sweep(input string tag, input logic [N-1:0] c, input logic [7:0] b,
                            input logic [7:0] t, input int rpct);
      int cyc;
      int stalls;
      int nspk;
      int k;
      int got[$];
      current   = c;
      beta      = b;
      threshold = t;
      start     = 1'b1;
      step();
      start     = 1'b0;
      current   = N'($urandom);
      beta      = 8'($urandom);
      threshold = 8'($urandom);
      check({tag, " busy"}, 32'(busy), 1);
      cyc    = 0;
      stalls = 0;
      while (!done && cyc < 400) begin
         aer_ready = ($urandom_range(0, 99) < rpct);
         if (aer_valid) begin
            if (aer_ready) got.push_back(int'(aer_addr));
            else stalls++;
         end
         step();
         cyc++;
      end
      nspk = $countones(exp_vec);
      check({tag, " done"}, 32'(done), 1);
      check({tag, " latency"}, cyc, N + nspk + stalls);
      check({tag, " spike_vec"}, 32'(spike_vec), 32'(exp_vec));
      check({tag, " spike_count"}, 32'(spike_count), nspk);
      check({tag, " events"}, got.size(), nspk);
      k = 0;
      for (int i = 0; i < N; i++) begin
         if (exp_vec[i]) begin
            if (k < got.size()) check($sformatf("%s aer%0d", tag, k), got[k], i);
            k++;
         end
      end
      step();
      check({tag, " done_pulse"}, 32'(done), 0);
      check({tag, " idle"}, 32'(busy), 0);
      aer_ready = 1'b1;
      check_mems(tag);
   endtask

   task automatic wait_sat(output int cyc);
      cyc = 0;
      while (!s_done && cyc < 50) begin
         step();
         cyc++;
      end
   endtask

   initial begin
      int           cyc;
      int           first;
      int           ndone;
      logic [N-1:0] rc;
      logic [N-1:0] rv;
      logic [7:0]   rb;
      logic [7:0]   rt;
      int           rp;

      tbl[0]  = '{1'b1, 8'hFF, 8'd255, 8'd200, 8'h00, 64,  0};
      tbl[1]  = '{1'b0, 8'hFF, 8'd255, 8'd200, 8'h00, 127, 0};
      tbl[2]  = '{1'b0, 8'hFF, 8'd255, 8'd200, 8'h00, 190, 0};
      tbl[3]  = '{1'b0, 8'hFF, 8'd255, 8'd200, 8'hFF, 0,   0};
      tbl[4]  = '{1'b1, 8'h00, 8'd255, 8'd10,  8'h00, 0,   0};
      tbl[5]  = '{1'b0, 8'hA5, 8'd0,   8'd64,  8'hA5, 0,   0};
      tbl[6]  = '{1'b1, 8'h3C, 8'd0,   8'd65,  8'h00, 64,  0};
      tbl[7]  = '{1'b0, 8'h3C, 8'd128, 8'd0,   8'hFF, 0,   0};
      tbl[8]  = '{1'b1, 8'h81, 8'd200, 8'd128, 8'h00, 64,  0};
      tbl[9]  = '{1'b0, 8'h81, 8'd200, 8'd128, 8'h00, 114, 0};
      tbl[10] = '{1'b0, 8'h81, 8'd200, 8'd128, 8'h81, 0,   0};

      rst_n = 1'b0; start = 1'b0; clear = 1'b0; current = '0;
      beta = '0; threshold = '0; aer_ready = 1'b1; mem_sel = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst aer_valid", 32'(aer_valid), 0);
      check("rst aer_addr", 32'(aer_addr), 0);
      check("rst spike_vec", 32'(spike_vec), 0);
      check("rst spike_count", 32'(spike_count), 0);
      set_exp('0, '0, 0, 0);
      check_mems("rst");
      rst_n = 1'b1;
      step();

      // Saturation on the GAIN=200 instance; the default instance runs alongside.
      current = 8'h01; beta = 8'd255; threshold = 8'd255; start = 1'b1;
      step();
      start = 1'b0;
      wait_sat(cyc);
      mem_sel = '0;
      #1;
      check("sat1 done", 32'(s_done), 1);
      check("sat1 latency", cyc, 8);
      check("sat1 spike_vec", 32'(s_spike_vec), 0);
      check("sat1 mem0", 32'(s_state_out), 200);
      check("sat1 dut mem0", 32'(state_out), 64);
      repeat (3) step();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_sat(cyc);
      mem_sel = '0;
      #1;
      check("sat2 done", 32'(s_done), 1);
      check("sat2 latency", cyc, 9);
      check("sat2 spike_vec", 32'(s_spike_vec), 1);
      check("sat2 spike_count", 32'(s_spike_count), 1);
      check("sat2 mem0", 32'(s_state_out), 0);
      check("sat2 dut mem0", 32'(state_out), 127);
      repeat (3) step();

      for (int r = 0; r < 11; r++) begin
         if (tbl[r].clr) do_clear();
         set_exp(tbl[r].cur, tbl[r].vec, tbl[r].on_v, tbl[r].off_v);
         run_sweep($sformatf("row%0d", r), tbl[r].cur, tbl[r].beta, tbl[r].thr, 100);
      end

      // Backpressure: neuron 3 fires, neuron 4 holds 64 until the event is accepted.
      do_clear();
      set_exp(8'h10, 8'h00, 64, 0);
      run_sweep("bp_pre", 8'h10, 8'd0, 8'd100, 100);
      mem_sel = AW'(4); aer_ready = 1'b0;
      current = 8'h08; beta = 8'd0; threshold = 8'd64; start = 1'b1;
      step();
      start = 1'b0;
      first = -1;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (c == 3) check("bp no_valid_yet", 32'(aer_valid), 0);
         if (c >= 4 && c <= 9) begin
            check($sformatf("bp valid c%0d", c), 32'(aer_valid), 1);
            check($sformatf("bp addr c%0d", c), 32'(aer_addr), 3);
         end
         if (c == 9) aer_ready = 1'b1;
         if (c == 10) begin
            check("bp valid_drop", 32'(aer_valid), 0);
            check("bp mem4_held", 32'(state_out), 64);
         end
         if (c == 11) check("bp mem4_updated", 32'(state_out), 0);
         if (done && first < 0) first = c;
      end
      check("bp done_latency", first, 14);
      check("bp spike_vec", 32'(spike_vec), 8'h08);
      set_exp('0, 8'h08, 0, 0);
      check_mems("bp");

      // Start while busy must neither restart nor alter the running sweep.
      do_clear();
      current = '0; beta = 8'd0; threshold = 8'd10; start = 1'b1;
      step();
      ndone = 0;
      first = -1;
      for (int c = 1; c <= 14; c++) begin
         start = (c == 3);
         current = '1;
         threshold = 8'd0;
         step();
         if (done) begin
            ndone++;
            if (first < 0) first = c;
         end
      end
      start = 1'b0;
      check("busy_start latency", first, 8);
      check("busy_start done_count", ndone, 1);
      check("busy_start idle", 32'(busy), 0);
      check("busy_start spike_vec", 32'(spike_vec), 0);
      set_exp('0, '0, 0, 0);
      check_mems("busy_start");

      // Clear together with start: membranes zeroed, no sweep.
      set_exp(8'hFF, 8'h00, 64, 0);
      run_sweep("cs_pre", 8'hFF, 8'd0, 8'd100, 100);
      clear = 1'b1; start = 1'b1;
      step();
      clear = 1'b0; start = 1'b0;
      check("cs busy0", 32'(busy), 0);
      step();
      check("cs busy1", 32'(busy), 0);
      check("cs done", 32'(done), 0);
      set_exp('0, '0, 0, 0);
      check_mems("cs");

      // Reset while an event is stalled in EMIT.
      set_exp(8'hF0, 8'h00, 64, 0);
      run_sweep("re_pre", 8'hF0, 8'd0, 8'd200, 100);
      aer_ready = 1'b0;
      current = 8'h01; beta = 8'd0; threshold = 8'd64; start = 1'b1;
      step();
      start = 1'b0;
      step();
      check("re emit_valid", 32'(aer_valid), 1);
      rst_n = 1'b0;
      #1;
      check("re aer_valid", 32'(aer_valid), 0);
      check("re busy", 32'(busy), 0);
      check("re aer_addr", 32'(aer_addr), 0);
      check("re spike_count", 32'(spike_count), 0);
      set_exp('0, '0, 0, 0);
      check_mems("re");
      step();
      rst_n = 1'b1;
      aer_ready = 1'b1;
      step();
      set_exp(8'hFF, 8'hFF, 0, 0);
      run_sweep("re_post", 8'hFF, 8'd0, 8'd64, 100);

      // Randomized sweeps against the reference model.
      do_clear();
      for (int i = 0; i < N; i++) model_mem[i] = 0;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 5) == 0) begin
            do_clear();
            for (int i = 0; i < N; i++) model_mem[i] = 0;
         end
         rc = N'($urandom);
         rb = 8'($urandom);
         rt = 8'($urandom_range(0, 220));
         case ($urandom_range(0, 2))
            0:       rp = 100;
            1:       rp = 60;
            default: rp = 25;
         endcase
         model_sweep(rc, int'(rb), int'(rt), 64, rv);
         exp_vec = rv;
         exp_mem = model_mem;
         run_sweep($sformatf("rnd%0d", it), rc, rb, rt, rp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lif_sequencer.md
LIF_SEQUENCER -- requirements
Module: lif_sequencer

Interface
REQ-001 SHALL provide parameter N_NEURONS, default 8, giving the number of time-multiplexed neurons (power of two, 2..16).
REQ-002 SHALL provide parameter GAIN, default 8'd64, giving the membrane increment applied when a neuron's input bit is 1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request one timestep sweep over all neurons; honoured only in IDLE.
REQ-006 SHALL have port clear, input, 1, synchronous zeroing of all membranes; honoured only in IDLE.
REQ-007 SHALL have port current, input, N_NEURONS, one input bit per neuron (bit i feeds neuron i), latched on an accepted start.
REQ-008 SHALL have port beta, input, 8, decay factor, latched on an accepted start.
REQ-009 SHALL have port threshold, input, 8, firing threshold, latched on an accepted start.
REQ-010 SHALL have port aer_ready, input, 1, downstream acceptance of a spike event.
REQ-011 SHALL have port aer_valid, output, 1, spike event present.
REQ-012 SHALL have port aer_addr, output, log2(N_NEURONS), index of the spiking neuron.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle pulse marking the end of a sweep.
REQ-015 SHALL have port spike_vec, output, N_NEURONS, per-neuron spikes of the last completed sweep.
REQ-016 SHALL have port spike_count, output, log2(N_NEURONS)+1, population count of spike_vec.
REQ-017 SHALL have port mem_sel, input, log2(N_NEURONS), selects the neuron for state_out.
REQ-018 SHALL have port state_out, output, 8, combinational read of membrane[mem_sel].

Function
REQ-019 SHALL implement FSM states IDLE, UPDATE, EMIT, DONE; transitions: IDLE->UPDATE on start (idx=0); UPDATE->EMIT on spike; UPDATE->UPDATE (idx+1) without spike and idx<N-1; UPDATE->DONE without spike and idx=N-1; EMIT->UPDATE (idx+1) or DONE on aer_ready; DONE->IDLE unconditionally.
REQ-020 SHALL compute in UPDATE: decayed = (mem[idx]*beta)>>8 (16-bit product, upper byte), next = decayed + (current[idx] ? GAIN : 0), saturated at 255.
REQ-021 SHALL fire when next >= threshold: mem[idx] <= 0, bit idx of the sweep spike accumulator set; otherwise mem[idx] <= next.
REQ-022 SHALL, in EMIT, hold aer_valid=1 and aer_addr=idx stable until aer_ready is sampled high; aer_valid SHALL be 0 in all other states.
REQ-023 SHALL have sweep latency, with no spikes: start sampled at edge k, neuron i updated at edge k+1+i, done high during the cycle after edge k+N; each spike adds 1 cycle plus the number of cycles aer_ready is low.
REQ-024 SHALL load spike_vec and spike_count from the accumulator on entry to DONE, and hold them until the next DONE; the accumulator SHALL be cleared on accepted start.
REQ-025 SHALL ignore start and clear while busy; if both are asserted in IDLE, clear SHALL take effect and start SHALL be ignored.
REQ-026 SHALL use only the latched current/beta/threshold during a sweep; input changes mid-sweep SHALL have no effect.
REQ-027 SHALL treat threshold=0 as "every neuron fires every sweep".

Reset
REQ-028 SHALL, on rst_n low at any time including mid-sweep or mid-EMIT, immediately force IDLE, all membranes 0, latched inputs 0, spike_vec 0, spike_count 0, aer_valid 0, aer_addr 0, busy 0, done 0.
REQ-029 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-030 SHALL verify integration: beta=255, threshold=200, current=8'hFF, aer_ready=1, four sweeps -> membranes 64, 127, 190, then fire; sweep 4 spike_vec=8'hFF, spike_count=8, membranes 0, 8 AER events at addrs 0..7 in order.
REQ-031 SHALL verify timing: current=0, start pulse at edge k -> busy from k, done high exactly one cycle after edge k+8, spike_vec=0, no aer_valid.
REQ-032 SHALL verify backpressure: neuron 3 fires with aer_ready low 5 cycles -> aer_valid/aer_addr=3 stable 6 cycles, done delayed by 6 cycles versus no spike, neuron 4 not updated until acceptance.
REQ-033 SHALL verify saturation: beta=255, threshold=255, GAIN=200, current[0]=1 -> sweep 1 mem[0]=200, no spike; sweep 2 sum 399 saturates at 255, fires, mem[0]=0.
REQ-034 SHALL verify control corners: start while busy ignored; clear with start in IDLE zeroes membranes and starts nothing; rst_n low during EMIT -> aer_valid 0 and all membranes 0 immediately.
